cla_15bit_top: RTL and testbench

CLA_15BIT_TOP -- requirements
Module: cla_15bit_top

---
 rtl/cla_15bit_top.sv | 132 +++++++++++++
 tb/tb_cla_15bit_top.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/cla_15bit_top.sv
// 15-bit registered adder/subtractor built from five 3-bit carry-lookahead slices
// and a second-level lookahead unit; one output register stage, latency 1.

module cla3_slice (
   input  logic       cin,
   input  logic [2:0] a,
   input  logic [2:0] bx,
   output logic [2:0] p,
   output logic [2:0] c,
   output logic       grp_g,
   output logic       grp_p
);

   logic [2:0] g;

   // All in-slice carries are expanded lookahead terms, not chained.
   always_comb begin
      g     = a & bx;
      p     = a ^ bx;
      c[0]  = cin;
      c[1]  = g[0] | (p[0] & cin);
      c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
      grp_g = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]);
      grp_p = p[2] & p[1] & p[0];
   end

endmodule

module cla_lookahead5 (
   input  logic       c0,
   input  logic [4:0] grp_g,
   input  logic [4:0] grp_p,
   output logic [5:1] c_slice
);

   // c_slice[k] is the carry into bit 3*k; every term depends only on c0 and G/P.
   always_comb begin
      c_slice[1] = grp_g[0]
                 | (grp_p[0] & c0);
      c_slice[2] = grp_g[1]
                 | (grp_p[1] & grp_g[0])
                 | (grp_p[1] & grp_p[0] & c0);
      c_slice[3] = grp_g[2]
                 | (grp_p[2] & grp_g[1])
                 | (grp_p[2] & grp_p[1] & grp_g[0])
                 | (grp_p[2] & grp_p[1] & grp_p[0] & c0);
      c_slice[4] = grp_g[3]
                 | (grp_p[3] & grp_g[2])
                 | (grp_p[3] & grp_p[2] & grp_g[1])
                 | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
                 | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & c0);
      c_slice[5] = grp_g[4]
                 | (grp_p[4] & grp_g[3])
                 | (grp_p[4] & grp_p[3] & grp_g[2])
                 | (grp_p[4] & grp_p[3] & grp_p[2] & grp_g[1])
                 | (grp_p[4] & grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
                 | (grp_p[4] & grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & c0);
   end

endmodule

module cla_15bit_top (
   input  logic        clk,
   input  logic        rst,
   input  logic [14:0] A,
   input  logic [14:0] B,
   input  logic        mode,
   output logic [14:0] S,
   output logic        Cout,
   output logic        Ovf
);

   logic [14:0] bx;
   logic        c0;
   logic [14:0] p_bus;
   logic [14:0] c_bus;
   logic [4:0]  grp_g;
   logic [4:0]  grp_p;
   logic [5:1]  c_slice;
   logic [4:0]  slice_cin;

   logic [14:0] s_d, s_q;
   logic        cout_d, cout_q;
   logic        ovf_d, ovf_q;

   // Subtraction is A + ~B + 1: invert B and inject mode as the carry-in.
   assign bx        = B ^ {15{mode}};
   assign c0        = mode;
   assign slice_cin = {c_slice[4:1], c0};

   for (genvar k = 0; k < 5; k++) begin : g_slice
      cla3_slice u_slice (
         .cin   (slice_cin[k]),
         .a     (A[3*k +: 3]),
         .bx    (bx[3*k +: 3]),
         .p     (p_bus[3*k +: 3]),
         .c     (c_bus[3*k +: 3]),
         .grp_g (grp_g[k]),
         .grp_p (grp_p[k])
      );
   end

   cla_lookahead5 u_lookahead (
      .c0      (c0),
      .grp_g   (grp_g),
      .grp_p   (grp_p),
      .c_slice (c_slice)
   );

   always_comb begin
      s_d    = p_bus ^ c_bus;
      cout_d = c_slice[5];
      ovf_d  = c_slice[5] ^ c_bus[14];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s_q    <= 15'd0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         s_q    <= s_d;
         cout_q <= cout_d;
         ovf_q  <= ovf_d;
      end
   end

   assign S    = s_q;
   assign Cout = cout_q;
   assign Ovf  = ovf_q;

endmodule

// File: tb/tb_cla_15bit_top.sv
// Directed and random checks of the registered 15-bit CLA adder/subtractor.

module tb_cla_15bit_top;

   logic        clk = 1'b0;
   logic        rst;
   logic [14:0] a_in;
   logic [14:0] b_in;
   logic        mode;
   logic [14:0] s_out;
   logic        cout_out;
   logic        ovf_out;

   int tests_run    = 0;
   int tests_failed = 0;

   cla_15bit_top dut (
      .clk  (clk),
      .rst  (rst),
      .A    (a_in),
      .B    (b_in),
      .mode (mode),
      .S    (s_out),
      .Cout (cout_out),
      .Ovf  (ovf_out)
   );

   always #5 clk = ~clk;

   // Drive on the falling edge, then look at the outputs just after the next rising edge.
   task automatic apply_op(input logic r, input logic [14:0] av, input logic [14:0] bv,
                           input logic m);
      @(negedge clk);
      rst  = r;
      a_in = av;
      b_in = bv;
      mode = m;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      apply_op(1'b1, 15'h7FFF, 15'h7FFF, 1'b1);
      tests_run++;
      if ({s_out, cout_out, ovf_out} !== {15'h0000, 1'b0, 1'b0}) begin
         tests_failed++;
         $display("[TB] FAIL reset_a: got S=%h Cout=%b Ovf=%b, want S=0000 Cout=0 Ovf=0",
                  s_out, cout_out, ovf_out);
      end
      apply_op(1'b1, 15'h4001, 15'h4000, 1'b0);
      tests_run++;
      if ({s_out, cout_out, ovf_out} !== {15'h0000, 1'b0, 1'b0}) begin
         tests_failed++;
         $display("[TB] FAIL reset_b: got S=%h Cout=%b Ovf=%b, want S=0000 Cout=0 Ovf=0",
                  s_out, cout_out, ovf_out);
      end
   endtask

   task automatic test_add_sub_table();
      logic [14:0] ta [9] = '{15'd0, 15'd25, 15'h2000, 15'h6000, 15'h4001,
                              15'd25, 15'h2000, 15'h6000, 15'h4002};
      logic [14:0] tb [9] = '{15'd0, 15'd50, 15'h2000, 15'h6000, 15'h4000,
                              15'h7FCE, 15'h6000, 15'h2000, 15'h3FFF};
      logic        tm [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      logic [14:0] es [9] = '{15'd0, 15'd75, 15'h4000, 15'h4000, 15'h0001,
                              15'd75, 15'h4000, 15'h4000, 15'h0003};
      logic        ec [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      logic        eo [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 9; i++) begin
         apply_op(1'b0, ta[i], tb[i], tm[i]);
         tests_run++;
         if ({s_out, cout_out, ovf_out} !== {es[i], ec[i], eo[i]}) begin
            tests_failed++;
            $display("[TB] FAIL case_%0d: got S=%h Cout=%b Ovf=%b, want S=%h Cout=%b Ovf=%b",
                     i + 1, s_out, cout_out, ovf_out, es[i], ec[i], eo[i]);
         end
      end
   endtask

   // Edge values around zero, -1 and the signed limits, issued on consecutive cycles.
   task automatic test_back_to_back();
      logic [14:0] ta [6] = '{15'h7FFF, 15'h3FFF, 15'd0,    15'h4000, 15'h7FFF, 15'h2AAA};
      logic [14:0] tb [6] = '{15'd1,    15'd1,    15'd1,    15'd1,    15'h7FFF, 15'h5555};
      logic        tm [6] = '{1'b0,     1'b0,     1'b1,     1'b1,     1'b1,     1'b0};
      logic [14:0] es [6] = '{15'd0,    15'h4000, 15'h7FFF, 15'h3FFF, 15'd0,    15'h7FFF};
      logic        ec [6] = '{1'b1,     1'b0,     1'b0,     1'b1,     1'b1,     1'b0};
      logic        eo [6] = '{1'b0,     1'b1,     1'b0,     1'b1,     1'b0,     1'b0};
      for (int i = 0; i < 6; i++) begin
         apply_op(1'b0, ta[i], tb[i], tm[i]);
         tests_run++;
         if ({s_out, cout_out, ovf_out} !== {es[i], ec[i], eo[i]}) begin
            tests_failed++;
            $display("[TB] FAIL b2b_%0d: got S=%h Cout=%b Ovf=%b, want S=%h Cout=%b Ovf=%b",
                     i, s_out, cout_out, ovf_out, es[i], ec[i], eo[i]);
         end
      end
   endtask

   task automatic test_mid_reset();
      apply_op(1'b0, 15'd25, 15'd50, 1'b0);
      tests_run++;
      if ({s_out, cout_out, ovf_out} !== {15'd75, 1'b0, 1'b0}) begin
         tests_failed++;
         $display("[TB] FAIL mid_pre: got S=%h Cout=%b Ovf=%b, want S=004b Cout=0 Ovf=0",
                  s_out, cout_out, ovf_out);
      end
      apply_op(1'b1, 15'h4001, 15'h4000, 1'b0);
      tests_run++;
      if ({s_out, cout_out, ovf_out} !== {15'd0, 1'b0, 1'b0}) begin
         tests_failed++;
         $display("[TB] FAIL mid_rst: got S=%h Cout=%b Ovf=%b, want S=0000 Cout=0 Ovf=0",
                  s_out, cout_out, ovf_out);
      end
      apply_op(1'b0, 15'h2000, 15'h2000, 1'b0);
      tests_run++;
      if ({s_out, cout_out, ovf_out} !== {15'h4000, 1'b0, 1'b1}) begin
         tests_failed++;
         $display("[TB] FAIL mid_release: got S=%h Cout=%b Ovf=%b, want S=4000 Cout=0 Ovf=1",
                  s_out, cout_out, ovf_out);
      end
   endtask

   task automatic test_hold_between_edges();
      apply_op(1'b0, 15'd100, 15'd200, 1'b0);
      tests_run++;
      if ({s_out, cout_out, ovf_out} !== {15'd300, 1'b0, 1'b0}) begin
         tests_failed++;
         $display("[TB] FAIL hold_first: got S=%h Cout=%b Ovf=%b, want S=012c Cout=0 Ovf=0",
                  s_out, cout_out, ovf_out);
      end
      @(negedge clk);
      a_in = 15'd1;
      b_in = 15'd1;
      mode = 1'b1;
      #2;
      tests_run++;
      if ({s_out, cout_out, ovf_out} !== {15'd300, 1'b0, 1'b0}) begin
         tests_failed++;
         $display("[TB] FAIL hold_stable: got S=%h Cout=%b Ovf=%b, want S=012c Cout=0 Ovf=0",
                  s_out, cout_out, ovf_out);
      end
      @(posedge clk);
      #1;
      tests_run++;
      if ({s_out, cout_out, ovf_out} !== {15'd0, 1'b1, 1'b0}) begin
         tests_failed++;
         $display("[TB] FAIL hold_next: got S=%h Cout=%b Ovf=%b, want S=0000 Cout=1 Ovf=0",
                  s_out, cout_out, ovf_out);
      end
   endtask

   // Reference: unsigned 16-bit sum for S/Cout, signed integer range test for Ovf.
   task automatic test_random_sweep();
      logic [14:0] ra, rb;
      logic        rm;
      logic [15:0] full;
      int          sa, sb, sr;
      logic [14:0] exp_s;
      logic        exp_c, exp_o;
      for (int i = 0; i < 300; i++) begin
         ra = 15'($urandom);
         rb = 15'($urandom);
         rm = 1'($urandom);
         if (i < 4) begin
            ra = (i % 2 == 0) ? 15'h4000 : 15'h3FFF;
            rb = (i < 2) ? 15'h4000 : 15'h3FFF;
         end
         full  = rm ? ({1'b0, ra} + {1'b0, ~rb} + 16'd1) : ({1'b0, ra} + {1'b0, rb});
         sa    = ra[14] ? int'(ra) - 32768 : int'(ra);
         sb    = rb[14] ? int'(rb) - 32768 : int'(rb);
         sr    = rm ? sa - sb : sa + sb;
         exp_s = full[14:0];
         exp_c = full[15];
         exp_o = (sr > 16383) || (sr < -16384);
         apply_op(1'b0, ra, rb, rm);
         tests_run++;
         if ({s_out, cout_out, ovf_out} !== {exp_s, exp_c, exp_o}) begin
            tests_failed++;
            $display("[TB] FAIL rand_%0d A=%h B=%h mode=%b: got S=%h Cout=%b Ovf=%b, want S=%h Cout=%b Ovf=%b",
                     i, ra, rb, rm, s_out, cout_out, ovf_out, exp_s, exp_c, exp_o);
         end
      end
   endtask

   initial begin
      rst  = 1'b1;
      a_in = 15'd0;
      b_in = 15'd0;
      mode = 1'b0;
      test_reset();
      test_add_sub_table();
      test_back_to_back();
      test_mid_reset();
      test_hold_between_edges();
      test_random_sweep();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
